fifo_rd_arb: RTL and testbench

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

---
 rtl/fifo_rd_arb.sv | 107 ++++++++++
 tb/tb_fifo_rd_arb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arb.sv
// Round-robin read arbiter over NUM_CH first-word-fall-through FIFOs. Each grant
// pops a burst of up to MAX_BURST words into a single registered output stage.
module fifo_rd_arb #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                         rd_clk_i,
  input  logic                         rd_rst_i,
  input  logic                         arb_en_i,
  input  logic [NUM_CH-1:0]            fifo_empty_i,
  input  logic [NUM_CH-1:0]            fifo_a_empty_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data_i,
  output logic [NUM_CH-1:0]            fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [$clog2(NUM_CH)-1:0]    m_ch_o,
  output logic                         m_last_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic                         busy_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       grant_q, last_grant_q, next_grant;
  logic                  found;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [CH_W-1:0]       ch_p0;
  logic                  last_p0, vld_p0;
  logic                  slot, load, last_word, start;

  // Scan from the farthest candidate to the nearest so the channel right after
  // last_grant overwrites any other hit; last_grant itself is scanned first.
  always_comb begin
    int idx;
    next_grant = '0;
    found      = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last_grant_q) + i) % NUM_CH;
      if (!fifo_empty_i[idx]) begin
        next_grant = CH_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign slot      = ~vld_p0 | m_ready_i;
  assign load      = (state_q == BURST) & slot & ~fifo_empty_i[grant_q];
  assign last_word = (cnt_q == CNT_W'(MAX_BURST - 1)) | fifo_a_empty_i[grant_q];
  assign start     = (state_q == IDLE) & arb_en_i & found;

  always_comb begin
    state_d      = state_q;
    fifo_rd_en_o = '0;
    case (state_q)
      IDLE:  if (start) state_d = BURST;
      BURST: if ((load & last_word) | (slot & fifo_empty_i[grant_q])) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load & ~rd_rst_i) fifo_rd_en_o[grant_q] = 1'b1;
  end

  always_ff @(posedge rd_clk_i) begin
    if (rd_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Output stage: one registered word, refilled whenever the slot is free
  always_ff @(posedge rd_clk_i) begin
    if (rd_rst_i) begin
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      data_p0      <= '0;
      ch_p0        <= '0;
      last_p0      <= 1'b0;
      vld_p0       <= 1'b0;
    end else begin
      if (start) begin
        grant_q      <= next_grant;
        last_grant_q <= next_grant;
        cnt_q        <= '0;
      end
      if (load) begin
        data_p0 <= fifo_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
        ch_p0   <= grant_q;
        last_p0 <= last_word;
        vld_p0  <= 1'b1;
        cnt_q   <= cnt_q + CNT_W'(1);
      end else if (m_ready_i) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign m_data_o  = data_p0;
  assign m_ch_o    = ch_p0;
  assign m_last_o  = last_p0;
  assign m_valid_o = vld_p0;
  assign busy_o    = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Randomized bench for fifo_rd_arb: queue-backed FIFOs feed the DUT and a
// transaction-level reference predicts pops and the output word every cycle.
module tb_fifo_rd_arb;
  localparam int NUM_CH     = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 8;

  logic                         clk;
  logic                         rd_rst_i, arb_en_i, m_ready_i;
  logic [NUM_CH-1:0]            fifo_empty_i, fifo_a_empty_i, fifo_rd_en_o;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data_i;
  logic [DATA_WIDTH-1:0]        m_data_o;
  logic [1:0]                   m_ch_o;
  logic                         m_last_o, m_valid_o, busy_o;

  fifo_rd_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .rd_clk_i(clk), .rd_rst_i(rd_rst_i), .arb_en_i(arb_en_i),
    .fifo_empty_i(fifo_empty_i), .fifo_a_empty_i(fifo_a_empty_i),
    .fifo_data_i(fifo_data_i), .fifo_rd_en_o(fifo_rd_en_o),
    .m_data_o(m_data_o), .m_ch_o(m_ch_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] fq [NUM_CH][$];
  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  // Reference state: which channel is bursting, how many words it has sent,
  // and the word currently presented downstream.
  bit                    md_busy  = 0;
  int                    md_grant = 0;
  int                    md_lastg = NUM_CH - 1;
  int                    md_cnt   = 0;
  bit                    md_vld   = 0;
  bit                    md_lastf = 0;
  logic [DATA_WIDTH-1:0] md_data  = '0;
  int                    md_ch    = 0;

  bit                    s_rst, s_en, s_ready;
  logic [NUM_CH-1:0]     s_empty, s_aempty;
  logic [DATA_WIDTH-1:0] s_data [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_flags();
    for (int k = 0; k < NUM_CH; k++) begin
      fifo_empty_i[k]   = (fq[k].size() == 0);
      fifo_a_empty_i[k] = (fq[k].size() == 1);
      fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH] = (fq[k].size() > 0) ? fq[k][0] : '0;
    end
  endtask

  task automatic push_word(input int c);
    logic [1:0] c2;
    logic [5:0] s6;
    c2 = c[1:0];
    s6 = seq[5:0];
    fq[c].push_back({c2, s6});
    seq++;
  endtask

  task automatic model_clock();
    bit room, hit;
    int c;
    if (s_rst) begin
      md_busy = 0; md_vld = 0; md_data = '0; md_ch = 0; md_lastf = 0;
      md_cnt = 0; md_lastg = NUM_CH - 1;
    end else if (!md_busy) begin
      if (s_ready) md_vld = 0;
      if (s_en && (s_empty != '1)) begin
        hit = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
          c = (md_lastg + i) % NUM_CH;
          if (!hit && !s_empty[c]) begin
            md_grant = c;
            hit = 1;
          end
        end
        md_lastg = md_grant;
        md_cnt   = 0;
        md_busy  = 1;
      end
    end else begin
      room = !md_vld || s_ready;
      if (room && !s_empty[md_grant]) begin
        md_data  = s_data[md_grant];
        md_ch    = md_grant;
        md_vld   = 1;
        md_lastf = (md_cnt == MAX_BURST - 1) || s_aempty[md_grant];
        md_cnt++;
        if (md_lastf) md_busy = 0;
      end else begin
        if (s_ready) md_vld = 0;
        if (room) md_busy = 0;
      end
    end
  endtask

  task automatic step(input int rdy_pct, input int en_pct, input int push_pct, input int rst_pct);
    logic [NUM_CH-1:0] exp_rd, pops;
    int c;
    @(negedge clk);
    rd_rst_i  = ($urandom_range(99) < rst_pct);
    arb_en_i  = ($urandom_range(99) < en_pct);
    m_ready_i = ($urandom_range(99) < rdy_pct);
    if ($urandom_range(99) < push_pct) begin
      c = $urandom_range(NUM_CH - 1);
      if (fq[c].size() < 24) push_word(c);
    end
    drive_flags();
    #1;
    s_rst = rd_rst_i; s_en = arb_en_i; s_ready = m_ready_i;
    s_empty = fifo_empty_i; s_aempty = fifo_a_empty_i;
    for (int k = 0; k < NUM_CH; k++) s_data[k] = fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    exp_rd = '0;
    if (!s_rst && md_busy && (!md_vld || s_ready) && !s_empty[md_grant]) exp_rd[md_grant] = 1'b1;
    chk("rd_en", 32'(fifo_rd_en_o), 32'(exp_rd));
    pops = fifo_rd_en_o;
    @(posedge clk);
    #1;
    model_clock();
    for (int k = 0; k < NUM_CH; k++)
      if (pops[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    drive_flags();
    chk("valid", 32'(m_valid_o), 32'(md_vld));
    chk("data",  32'(m_data_o),  32'(md_data));
    chk("ch",    32'(m_ch_o),    md_ch);
    chk("last",  32'(m_last_o),  32'(md_lastf));
    chk("busy",  32'(busy_o),    32'(md_busy));
  endtask

  initial begin
    rd_rst_i = 1'b1; arb_en_i = 1'b0; m_ready_i = 1'b0;
    drive_flags();

    repeat (3) step(100, 0, 0, 100);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o),    32'd0);

    // Three words on channel 0 only, downstream always ready
    fq[0].push_back(8'h0A); fq[0].push_back(8'h0B); fq[0].push_back(8'h0C);
    repeat (8) step(100, 100, 0, 0);

    // Every channel deep enough for several full-length bursts
    for (int k = 0; k < NUM_CH; k++) repeat (20) push_word(k);
    repeat (200) step(100, 100, 0, 0);

    repeat (3000) step(70, 90, 45, 1);
    repeat (1500) step(25, 60, 60, 1);

    // Arbitration disabled with data waiting: no grant may start
    for (int k = 0; k < NUM_CH; k++) repeat (5) push_word(k);
    repeat (30) step(100, 0, 0, 0);
    repeat (300) step(100, 100, 0, 0);
    chk("drained_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
